waveform_recorder: RTL

WAVEFORM_RECORDER -- requirements
Module: waveform_recorder

---
 rtl/waveform_recorder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/waveform_recorder.sv
// Triggered waveform capture into an inferred simple dual-port sample RAM with registered readback.
// Define WAVEFORM_RECORDER_PRETRIGGER_EN to record continuously while armed (pre-trigger history).
module waveform_recorder #(
    parameter int DATA_BUS_WIDTH    = 8,
    parameter int ADDRESS_BUS_DEPTH = 11
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [DATA_BUS_WIDTH-1:0]    data_in,
    input  logic                         arm,
    input  logic                         trigger,
    input  logic [ADDRESS_BUS_DEPTH-1:0] capture_length,
    input  logic [ADDRESS_BUS_DEPTH-1:0] read_address,
    output logic [DATA_BUS_WIDTH-1:0]    read_data,
    output logic                         armed,
    output logic                         busy,
    output logic                         done,
    output logic [ADDRESS_BUS_DEPTH-1:0] trigger_address
);

    localparam int DEPTH = 2 ** ADDRESS_BUS_DEPTH;
    localparam logic [ADDRESS_BUS_DEPTH:0]   FULL_DEPTH = {1'b1, {ADDRESS_BUS_DEPTH{1'b0}}};
    localparam logic [ADDRESS_BUS_DEPTH:0]   ONE_SAMPLE = {{ADDRESS_BUS_DEPTH{1'b0}}, 1'b1};
    localparam logic [ADDRESS_BUS_DEPTH-1:0] ADDR_STEP  = {{(ADDRESS_BUS_DEPTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t                         state;
    logic [DATA_BUS_WIDTH-1:0]      memory [DEPTH];
    logic [ADDRESS_BUS_DEPTH-1:0]   write_pointer;
    logic [ADDRESS_BUS_DEPTH:0]     sample_count;
    logic [ADDRESS_BUS_DEPTH:0]     latched_length;
    logic                           write_enable;

    // Reset gates the write port so an aborted capture leaves the RAM untouched on the reset edge.
    always_comb begin
        write_enable = 1'b0;
        if (!reset) begin
            case (state)
`ifdef WAVEFORM_RECORDER_PRETRIGGER_EN
                ARMED:   write_enable = 1'b1;
`else
                ARMED:   write_enable = trigger;
`endif
                CAPTURE: write_enable = 1'b1;
                default: write_enable = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (write_enable) begin
            memory[write_pointer] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_data <= '0;
        end else begin
            read_data <= memory[read_address];
        end
    end

    // The counter is one bit wider than the address so a zero length means a full-depth capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            armed           <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            trigger_address <= '0;
            write_pointer   <= '0;
            sample_count    <= '0;
            latched_length  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        latched_length <= (capture_length == '0) ? FULL_DEPTH
                                                                 : {1'b0, capture_length};
                        write_pointer  <= '0;
                        state          <= ARMED;
                        armed          <= 1'b1;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                    end
                end
                ARMED: begin
                    if (trigger) begin
                        trigger_address <= write_pointer;
                        write_pointer   <= write_pointer + ADDR_STEP;
                        sample_count    <= ONE_SAMPLE;
                        armed           <= 1'b0;
                        if (latched_length == ONE_SAMPLE) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
`ifdef WAVEFORM_RECORDER_PRETRIGGER_EN
                    else begin
                        write_pointer <= write_pointer + ADDR_STEP;
                    end
`endif
                end
                CAPTURE: begin
                    write_pointer <= write_pointer + ADDR_STEP;
                    sample_count  <= sample_count + ONE_SAMPLE;
                    if (sample_count + ONE_SAMPLE == latched_length) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
